// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display: drives the nibble mux select/enable and active-low anodes.
// Optional inter-digit dead time is compiled in with `define DIGIT_SCAN_DEADTIME_EN.
module digit_scan_ctrl #(
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] blank_mask,
    output logic [1:0] select,
    output logic       enable,
    output logic [3:0] an,
    output logic       digit_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;
    logic [1:0]    d;
    logic          run_q;
    logic [3:0]    blank_q;
    logic          dead;
    logic          lit;

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("digit_scan_ctrl: PRESCALE must be at least 2");
    end

    if (DEAD_CYCLES < 0) begin : g_bad_dead_neg
        $error("digit_scan_ctrl: DEAD_CYCLES must not be negative");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p          <= '0;
            d          <= '0;
            run_q      <= 1'b0;
            blank_q    <= '0;
            digit_tick <= 1'b0;
        end else begin
            run_q   <= run;
            blank_q <= blank_mask;
            if (!run) begin
                p          <= '0;
                d          <= '0;
                digit_tick <= 1'b0;
            end else if (run_q) begin
                if (p == P_LAST) begin
                    p          <= '0;
                    d          <= d + 2'd1;
                    digit_tick <= 1'b1;
                end else begin
                    p          <= p + PW'(1);
                    digit_tick <= 1'b0;
                end
            end else begin
                // First cycle after run rises: digit 0 starts its full period from here.
                p          <= '0;
                d          <= '0;
                digit_tick <= 1'b0;
            end
        end
    end

`ifdef DIGIT_SCAN_DEADTIME_EN
    localparam logic [PW-1:0] DEAD_LIM = PW'(DEAD_CYCLES);

    if (DEAD_CYCLES >= PRESCALE) begin : g_bad_dead
        $error("digit_scan_ctrl: DEAD_CYCLES must be less than PRESCALE");
    end

    assign dead = (p < DEAD_LIM);
`else
    assign dead = 1'b0;
`endif

    // Outputs decode from flops only, so select and an always switch on the same edge.
    always_comb begin
        lit    = run_q & ~blank_q[d] & ~dead;
        select = d;
        enable = lit;
        an     = lit ? ~(4'b0001 << d) : 4'b1111;
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl with PRESCALE=8, DEAD_CYCLES=2.
// Expected dead-time behaviour follows whether DIGIT_SCAN_DEADTIME_EN is defined for the build.
module tb_digit_scan_ctrl;

    localparam int PRESCALE    = 8;
    localparam int DEAD_CYCLES = 2;
`ifdef DIGIT_SCAN_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] blank_mask;
    logic [1:0] select;
    logic       enable;
    logic [3:0] an;
    logic       digit_tick;

    int errors = 0;
    int checks = 0;

    digit_scan_ctrl #(
        .PRESCALE   (PRESCALE),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .blank_mask(blank_mask),
        .select    (select),
        .enable    (enable),
        .an        (an),
        .digit_tick(digit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k counts cycles since the first edge that saw run=1 (k=0: digit 0, phase 0).
    function automatic logic [1:0] exp_sel(input int k);
        return 2'((k / PRESCALE) % 4);
    endfunction

    function automatic logic exp_lit(input int k, input logic [3:0] mask);
        logic [1:0] s;
        int ph;
        s  = exp_sel(k);
        ph = k % PRESCALE;
        return !mask[s] && !(DEAD_EN && ph < DEAD_CYCLES);
    endfunction

    function automatic logic [3:0] exp_an(input int k, input logic [3:0] mask);
        logic [1:0] s;
        s = exp_sel(k);
        if (!exp_lit(k, mask)) return 4'b1111;
        case (s)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic exp_tick(input int k);
        return (k > 0) && (k % PRESCALE == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear the scan, load the mask, then take the edge where run is first seen.
    task automatic start_scan(input logic [3:0] mask);
        run        = 1'b0;
        blank_mask = mask;
        step();
        run = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        run        = 1'b1;
        blank_mask = 4'b0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (select !== 2'd0 || enable !== 1'b0 || an !== 4'b1111 || digit_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: select=%0d enable=%b an=%b tick=%b, required select=0 enable=0 an=1111 tick=0",
                         i, select, enable, an, digit_tick);
            end
            step();
        end
        rst_n = 1'b1;
        run   = 1'b0;
        step();
    endtask

    task automatic test_free_scan();
        start_scan(4'b0000);
        for (int k = 0; k < 4 * PRESCALE + 2; k++) begin
            checks++;
            if (select !== exp_sel(k) || enable !== exp_lit(k, 4'b0000) ||
                an !== exp_an(k, 4'b0000) || digit_tick !== exp_tick(k)) begin
                errors++;
                $display("FAIL free_scan[k=%0d]: select=%0d enable=%b an=%b tick=%b, required select=%0d enable=%b an=%b tick=%b",
                         k, select, enable, an, digit_tick,
                         exp_sel(k), exp_lit(k, 4'b0000), exp_an(k, 4'b0000), exp_tick(k));
            end
            step();
        end
    endtask

    task automatic test_blanking();
        start_scan(4'b0100);
        for (int k = 0; k < 4 * PRESCALE + 1; k++) begin
            checks++;
            if (select !== exp_sel(k) || enable !== exp_lit(k, 4'b0100) ||
                an !== exp_an(k, 4'b0100) || digit_tick !== exp_tick(k)) begin
                errors++;
                $display("FAIL blanking[k=%0d]: select=%0d enable=%b an=%b tick=%b, required select=%0d enable=%b an=%b tick=%b",
                         k, select, enable, an, digit_tick,
                         exp_sel(k), exp_lit(k, 4'b0100), exp_an(k, 4'b0100), exp_tick(k));
            end
            step();
        end
        // Mid-period of digit 2: clearing the mask relights one cycle later.
        start_scan(4'b0100);
        for (int k = 0; k < 2 * PRESCALE + 3; k++) step();
        checks++;
        if (select !== 2'd2 || enable !== 1'b0 || an !== 4'b1111) begin
            errors++;
            $display("FAIL blank_hold: select=%0d enable=%b an=%b, required select=2 enable=0 an=1111",
                     select, enable, an);
        end
        blank_mask = 4'b0000;
        #1;
        checks++;
        if (enable !== 1'b0 || an !== 4'b1111) begin
            errors++;
            $display("FAIL blank_latency: enable=%b an=%b, required enable=0 an=1111 before the edge",
                     enable, an);
        end
        step();
        checks++;
        if (select !== 2'd2 || enable !== 1'b1 || an !== 4'b1011) begin
            errors++;
            $display("FAIL blank_clear: select=%0d enable=%b an=%b, required select=2 enable=1 an=1011",
                     select, enable, an);
        end
    endtask

    task automatic test_run_drop();
        start_scan(4'b0000);
        for (int k = 0; k < 2 * PRESCALE + 4; k++) step();
        checks++;
        if (select !== 2'd2) begin
            errors++;
            $display("FAIL drop_pos: select=%0d, required 2", select);
        end
        run = 1'b0;
        step();
        checks++;
        if (select !== 2'd0 || enable !== 1'b0 || an !== 4'b1111 || digit_tick !== 1'b0) begin
            errors++;
            $display("FAIL run_drop: select=%0d enable=%b an=%b tick=%b, required select=0 enable=0 an=1111 tick=0",
                     select, enable, an, digit_tick);
        end
        run = 1'b1;
        step();
        for (int k = 0; k < PRESCALE + 1; k++) begin
            checks++;
            if (select !== exp_sel(k) || enable !== exp_lit(k, 4'b0000) ||
                an !== exp_an(k, 4'b0000) || digit_tick !== exp_tick(k)) begin
                errors++;
                $display("FAIL restart[k=%0d]: select=%0d enable=%b an=%b tick=%b, required select=%0d enable=%b an=%b tick=%b",
                         k, select, enable, an, digit_tick,
                         exp_sel(k), exp_lit(k, 4'b0000), exp_an(k, 4'b0000), exp_tick(k));
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        start_scan(4'b0000);
        for (int k = 0; k < 3 * PRESCALE + 3; k++) step();
        checks++;
        if (select !== 2'd3 || an !== 4'b0111) begin
            errors++;
            $display("FAIL areset_pos: select=%0d an=%b, required select=3 an=0111", select, an);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (select !== 2'd0 || enable !== 1'b0 || an !== 4'b1111 || digit_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: select=%0d enable=%b an=%b tick=%b, required select=0 enable=0 an=1111 tick=0",
                     select, enable, an, digit_tick);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < PRESCALE + 2; k++) begin
            checks++;
            if (select !== exp_sel(k) || enable !== exp_lit(k, 4'b0000) ||
                an !== exp_an(k, 4'b0000) || digit_tick !== exp_tick(k)) begin
                errors++;
                $display("FAIL post_reset[k=%0d]: select=%0d enable=%b an=%b tick=%b, required select=%0d enable=%b an=%b tick=%b",
                         k, select, enable, an, digit_tick,
                         exp_sel(k), exp_lit(k, 4'b0000), exp_an(k, 4'b0000), exp_tick(k));
            end
            step();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        blank_mask = 4'b0000;
        test_reset();
        test_free_scan();
        test_blanking();
        test_run_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion before 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display path. It sits directly upstream of the 4:1 nibble mux and drives the mux's `select[1:0]` and `Enable` inputs. It also drives the matching active-low anode lines, so each digit value and its anode advance together at a fixed, persistence-safe refresh rate. Optional per-digit blanking and an inter-digit dead time suppress ghosting.

## Interface
Parameters:
- `PRESCALE`, 100000, clock cycles per digit period; legal range is ≥ 2. At 100 MHz the default gives 1 kHz per digit and 250 Hz per frame.
- `DEAD_CYCLES`, 1000, blanked cycles at the start of each digit period; legal range is 0 ≤ DEAD_CYCLES < PRESCALE. Used only with `DEADTIME_EN`.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `run` input 1: scan enable; when 0 the display is blanked and the counters are cleared.
- `blank_mask` input 4: bit i = 1 forces digit i dark.
- `select` output 2: digit index to the mux select input.
- `enable` output 1: to the mux `Enable` input; 1 means the current digit is lit.
- `an` output 4: active-low one-hot anodes; 4'b1111 means all digits off.
- `digit_tick` output 1: one-cycle pulse on the first cycle of each new digit period.

## Operation
Registered state:
- `p`: prescaler, width $clog2(PRESCALE).
- `d`: 2-bit digit counter.
- `run_q`: `run` registered.
- `blank_q`: `blank_mask` registered every cycle.
- `digit_tick`: a flop.

Reset values, all asynchronous: p=0, d=0, run_q=0, blank_q=0, digit_tick=0. At reset the outputs are therefore select=0, enable=0, an=4'b1111, digit_tick=0.

Per clock edge:
- `run_q <= run` and `blank_q <= blank_mask`.
- If `run`=0: p<=0, d<=0, digit_tick<=0.
- Else if `run_q`=1:
  - If p==PRESCALE-1: p<=0, d<=d+1 (wraps 3→0), digit_tick<=1.
  - Otherwise: p<=p+1, digit_tick<=0.
- Else (the first cycle after `run` rises): p, d held at 0, digit_tick<=0.

Outputs are decoded combinationally from flops only; no input has a direct combinational path to any output:
- `select = d`.
- `lit = run_q & ~blank_q[d] & ~dead`.
  - With `DEADTIME_EN`: `dead = (p < DEAD_CYCLES)`.
  - Without it: `dead = 0`.
- `enable = lit`.
- `an = lit ? ~(4'b0001 << d) : 4'b1111`.

Boundary rules:
- Digit wrap from 3 to 0 is a normal advance; `digit_tick` pulses.
- A blanked digit still occupies its full period. `select` still advances and `digit_tick` still pulses for it.
- If `run` falls mid-period, the counters clear at the next edge and the display goes dark. The next `run` rise restarts at digit 0 with a full period.
- A `blank_mask` change takes effect one cycle later, even mid-period.
- Asserting `rst_n` low mid-operation forces reset values immediately, without a clock.

## Timing
- `run` rising at edge N:
  - Edge N+1: run_q=1, display lit for digit 0 (subject to mask and dead time).
  - Digit 0 then lasts exactly PRESCALE cycles.
- Every digit period is exactly PRESCALE cycles while `run` stays 1.
- `digit_tick` is high during the cycle in which `select` first shows the new digit.
- Latency is 1 cycle from `blank_mask` to enable/an, and 1 cycle from `run` falling to dark.
- `select` and `an` change on the same edge, so the mux output and anode are always consistent.

## Configuration
- Macro `DIGIT_SCAN_DEADTIME_EN`, defined:
  - The first DEAD_CYCLES cycles of every digit period have enable=0 and an=4'b1111.
  - A DEAD_CYCLES value of PRESCALE or more is a parameter error, flagged by a synthesis-time check.
- Macro undefined:
  - `dead` logic is removed and DEAD_CYCLES is ignored.
  - Each digit is lit for all PRESCALE cycles.

## Test plan
All scenarios use PRESCALE=8 and DEAD_CYCLES=2.
- Reset: hold rst_n=0 with run=1 and toggle clk → select=0, enable=0, an=4'b1111, digit_tick=0 throughout.
- Free scan: macro undefined, blank_mask=0, raise run:
  - select runs 0,1,2,3,0, with 8 cycles each.
  - an runs 1110, 1101, 1011, 0111 in step with select.
  - enable is constantly 1 after the first cycle.
  - digit_tick pulses every 8 cycles, including on the 3→0 wrap.
- Dead time: macro defined, same stimulus → in each 8-cycle digit period, enable=0 and an=1111 for the first 2 cycles, then lit for 6.
- Blanking: blank_mask=4'b0100 →
  - During the select=2 period: enable=0, an=1111.
  - digit_tick still pulses on entry to and exit from digit 2.
  - Clearing the mask mid-period relights the display 1 cycle later.
- Run drop and restart: deassert run during digit 2, cycle 4 →
  - Next edge: select=0, enable=0, an=1111.
  - Reassert run: digit 0 is lit one cycle later and lasts a full 8 cycles.
- Async reset mid-scan: pull rst_n low between clock edges during digit 3 → outputs go to reset values immediately; after release plus run, the scan restarts at digit 0.
